div_seq: RTL and testbench

- Sequential restoring divider: the inverse datapath of the carry-save/ripple adder and multiplier blocks.
- Takes a 2N-bit dividend and an N-bit divisor. Returns a 2N-bit quotient and an N-bit remainder.
- Produces one quotient bit per clock using one N+1-bit subtract per cycle.
- Sits beside the multiplier as the divide/verify path. It is also used to check multiplier products by dividing them back.

---
 rtl/div_seq.sv | 112 +++++++++++
 tb/tb_div_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> 2N-bit quotient, N-bit remainder.
// One quotient bit per clock; divide-by-zero completes immediately with an all-ones quotient.
module div_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r,
  output logic           busy,
  output logic           done,
  output logic           dz
);

  localparam int CW = $clog2(2*N+1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state, state_n;
  logic [2*N-1:0] dvd, dvd_n;
  logic [2*N-1:0] qs, qs_n;
  logic [N-1:0]   dvs;
  logic [N-1:0]   p, p_n;
  logic [N:0]     t, diff;
  logic [CW-1:0]  cnt;
  logic           qbit;
  logic           last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves state_n unassigned (no latch).
    state_n = state;
    case (state)
      IDLE:    if (start && (b != '0)) state_n = RUN;
      RUN:     if (cnt == CW'(1))      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == RUN);
  end

  // One restoring step. The partial remainder is always below the divisor, so the
  // trial value is below twice the divisor and the borrow out of the N+1-bit subtract
  // alone decides the quotient bit; the kept remainder then fits in N bits.
  assign t     = {p, dvd[2*N-1]};
  assign diff  = t - {1'b0, dvs};
  assign qbit  = ~diff[N];
  assign p_n   = qbit ? diff[N-1:0] : t[N-1:0];
  assign qs_n  = {qs[2*N-2:0], qbit};
  assign dvd_n = {dvd[2*N-2:0], 1'b0};
  assign last  = (state == RUN) && (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd  <= '0;
      dvs  <= '0;
      p    <= '0;
      qs   <= '0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
      dz   <= 1'b0;
      done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (b == '0) begin
            q    <= '1;
            r    <= '0;
            dz   <= 1'b1;
            done <= 1'b1;
          end else begin
            dvd <= a;
            dvs <= b;
            p   <= '0;
            qs  <= '0;
            cnt <= CW'(2*N);
          end
        end
      end else begin
        dvd <= dvd_n;
        p   <= p_n;
        qs  <= qs_n;
        cnt <= cnt - CW'(1);
        if (last) begin
          q    <= qs_n;
          r    <= p_n;
          dz   <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed and random checks of div_seq (N=8): latency, results, divide-by-zero,
// ignored start while busy, back-to-back start and asynchronous reset mid-run.
module tb_div_seq;

  localparam int N = 8;

  logic           clk   = 1'b0;
  logic           rst   = 1'b0;
  logic           start = 1'b0;
  logic [2*N-1:0] a     = '0;
  logic [N-1:0]   b     = '0;
  logic [2*N-1:0] q;
  logic [N-1:0]   r;
  logic           busy;
  logic           done;
  logic           dz;

  int total = 0;
  int bad   = 0;

  div_seq #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  // Issue one request, then count edges until done (lat=-1 on timeout) and busy samples.
  task automatic run_div(input logic [2*N-1:0] av, input logic [N-1:0] bv,
                         output int lat, output int busy_cnt);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 8'($urandom);
    lat = -1;
    busy_cnt = 0;
    if (done) lat = 0;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      if (done) lat = i;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk); start = 1'b1; a = 16'd500; b = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    total++; if (q !== '0)    begin bad++; $display("FAIL reset_q: got %0d expected 0", q); end
    total++; if (r !== '0)    begin bad++; $display("FAIL reset_r: got %0d expected 0", r); end
    total++; if (busy !== 0)  begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    total++; if (done !== 0)  begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
    total++; if (dz !== 0)    begin bad++; $display("FAIL reset_dz: got %0b expected 0", dz); end
    @(negedge clk); start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    run_div(16'd1000, 8'd7, lat, bc);
    total++; if (lat !== 16) begin bad++; $display("FAIL basic_latency: got %0d expected 16", lat); end
    total++; if (bc !== 16)  begin bad++; $display("FAIL basic_busy_cycles: got %0d expected 16", bc); end
    total++; if (q !== 16'd142) begin bad++; $display("FAIL basic_q: got %0d expected 142", q); end
    total++; if (r !== 8'd6)    begin bad++; $display("FAIL basic_r: got %0d expected 6", r); end
    total++; if (dz !== 1'b0)   begin bad++; $display("FAIL basic_dz: got %0b expected 0", dz); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %0b expected 0", done); end
    total++; if (q !== 16'd142) begin bad++; $display("FAIL basic_q_hold: got %0d expected 142", q); end
  endtask

  task automatic test_extremes();
    int lat, bc;
    run_div(16'd65535, 8'd255, lat, bc);
    total++; if (lat !== 16) begin bad++; $display("FAIL max255_latency: got %0d expected 16", lat); end
    total++; if (q !== 16'h0101) begin bad++; $display("FAIL max255_q: got %0d expected 257", q); end
    total++; if (r !== 8'd0)     begin bad++; $display("FAIL max255_r: got %0d expected 0", r); end
    run_div(16'd65535, 8'd1, lat, bc);
    total++; if (q !== 16'd65535) begin bad++; $display("FAIL max1_q: got %0d expected 65535", q); end
    total++; if (r !== 8'd0)      begin bad++; $display("FAIL max1_r: got %0d expected 0", r); end
    run_div(16'd100, 8'd200, lat, bc);
    total++; if (lat !== 16) begin bad++; $display("FAIL small_latency: got %0d expected 16", lat); end
    total++; if (q !== 16'd0)   begin bad++; $display("FAIL small_q: got %0d expected 0", q); end
    total++; if (r !== 8'd100)  begin bad++; $display("FAIL small_r: got %0d expected 100", r); end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_div(16'd1234, 8'd0, lat, bc);
    total++; if (lat !== 0)      begin bad++; $display("FAIL dz_latency: got %0d expected 0", lat); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL dz_busy: got %0b expected 0", busy); end
    total++; if (q !== 16'hFFFF) begin bad++; $display("FAIL dz_q: got %0h expected ffff", q); end
    total++; if (r !== 8'd0)     begin bad++; $display("FAIL dz_r: got %0d expected 0", r); end
    total++; if (dz !== 1'b1)    begin bad++; $display("FAIL dz_flag: got %0b expected 1", dz); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL dz_done_pulse: got %0b expected 0", done); end
    total++; if (dz !== 1'b1)    begin bad++; $display("FAIL dz_hold: got %0b expected 1", dz); end
    run_div(16'd9, 8'd3, lat, bc);
    total++; if (q !== 16'd3)  begin bad++; $display("FAIL after_dz_q: got %0d expected 3", q); end
    total++; if (r !== 8'd0)   begin bad++; $display("FAIL after_dz_r: got %0d expected 0", r); end
    total++; if (dz !== 1'b0)  begin bad++; $display("FAIL after_dz_flag: got %0b expected 0", dz); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 16'd50; b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
      if (i == 4) begin start = 1'b1; a = 16'd77; b = 8'd3; end
      else if (i == 5) start = 1'b0;
    end
    total++; if (lat !== 16)  begin bad++; $display("FAIL ignore_latency: got %0d expected 16", lat); end
    total++; if (q !== 16'd10) begin bad++; $display("FAIL ignore_q: got %0d expected 10", q); end
    total++; if (r !== 8'd0)   begin bad++; $display("FAIL ignore_r: got %0d expected 0", r); end
    // Still in the done cycle: busy is low, so this start is taken.
    start = 1'b1; a = 16'd77; b = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %0b expected 1", busy); end
    total++; if (q !== 16'd10)  begin bad++; $display("FAIL b2b_q_hold: got %0d expected 10", q); end
    lat = -1;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
    total++; if (lat !== 16)   begin bad++; $display("FAIL b2b_latency: got %0d expected 16", lat); end
    total++; if (q !== 16'd25) begin bad++; $display("FAIL b2b_q: got %0d expected 25", q); end
    total++; if (r !== 8'd2)   begin bad++; $display("FAIL b2b_r: got %0d expected 2", r); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    @(negedge clk);
    a = 16'd1000; b = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (q !== '0)    begin bad++; $display("FAIL mid_rst_q: got %0d expected 0", q); end
    total++; if (r !== '0)    begin bad++; $display("FAIL mid_rst_r: got %0d expected 0", r); end
    total++; if (busy !== 0)  begin bad++; $display("FAIL mid_rst_busy: got %0b expected 0", busy); end
    total++; if (done !== 0)  begin bad++; $display("FAIL mid_rst_done: got %0b expected 0", done); end
    total++; if (dz !== 0)    begin bad++; $display("FAIL mid_rst_dz: got %0b expected 0", dz); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_rst_no_done: got %0d active cycles expected 0", seen); end
    run_div(16'd1000, 8'd7, lat, bc);
    total++; if (lat !== 16)    begin bad++; $display("FAIL post_rst_latency: got %0d expected 16", lat); end
    total++; if (q !== 16'd142) begin bad++; $display("FAIL post_rst_q: got %0d expected 142", q); end
    total++; if (r !== 8'd6)    begin bad++; $display("FAIL post_rst_r: got %0d expected 6", r); end
  endtask

  task automatic test_random();
    int lat, bc, av, bv;
    for (int k = 0; k < 1000; k++) begin
      av = int'($urandom_range(0, 65535));
      bv = int'($urandom_range(1, 255));
      run_div(16'(av), 8'(bv), lat, bc);
      total++;
      if (lat !== 16 || (int'(q) * bv + int'(r)) !== av || int'(r) >= bv || dz !== 1'b0) begin
        bad++;
        $display("FAIL random_%0d: a=%0d b=%0d got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=16",
                 k, av, bv, q, r, lat, av / bv, av % bv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
